picosoc_iomem_timer: RTL and testbench
======================================

PICOSOC_IOMEM_TIMER -- requirements
Module: picosoc_iomem_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000: register window base (256-byte window, decode on addr[31:8]).
REQ-002 SHALL have parameter PRESCALE_W, default 16: prescaler register and counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iomem_valid  input  1  request from the SoC iomem bus.
REQ-006 SHALL have port iomem_ready  output  1  one-cycle completion strobe.
REQ-007 SHALL have port iomem_wstrb  input  4  byte write strobes; 4'b0000 = read.
REQ-008 SHALL have port iomem_addr  input  32  byte address.
REQ-009 SHALL have port iomem_wdata  input  32  write data.
REQ-010 SHALL have port iomem_rdata  output  32  read data, valid while iomem_ready=1, else 32'h0.
REQ-011 SHALL have port irq  output  1  level interrupt, intended for SoC irq_5.

Function
REQ-012 SHALL select when iomem_valid && iomem_addr[31:8]==BASE_ADDR[31:8]; if not selected, never assert iomem_ready.
REQ-013 SHALL use bus FSM IDLE->ACK on select; ACK->IDLE unconditionally; iomem_ready=1 only in ACK; latency = exactly one wait state (ready in 2nd cycle of valid).
REQ-014 SHALL perform the register write on the IDLE->ACK edge and capture rdata at that edge; there is one access per ACK, none while in ACK.
REQ-015 SHALL map offsets: 0x00 CTRL {[0] en, [1] irq_en, [2] autoreload}; 0x04 COUNT (32b RW); 0x08 COMPARE (32b RW); 0x0C PRESCALE (PRESCALE_W bits RW, upper bits read 0); 0x10 STATUS {[0] match}, write-1-to-clear.
REQ-016 SHALL honour wstrb per byte on all RW registers; STATUS clear uses wdata[0] only when wstrb[0]=1.
REQ-017 SHALL read unmapped offsets as 32'h0, ignore writes to them, and still complete them with iomem_ready.
REQ-018 SHALL, while en=1, increment the prescale counter each cycle; when it equals PRESCALE it resets to 0 and issues a one-cycle tick (PRESCALE=0 gives a tick every cycle).
REQ-019 SHALL on tick: if COUNT==COMPARE set match, and load COUNT=0 if autoreload else COUNT+1; otherwise COUNT+1; wrap 32'hFFFF_FFFF->0 with no flag.
REQ-020 SHALL clear the prescale counter when en=0; COUNT holds.
REQ-021 SHALL give a bus write to COUNT priority over a same-cycle tick update (tick lost, match compare still evaluated on old COUNT).
REQ-022 SHALL keep match set when a STATUS clear and a new match occur in the same cycle.
REQ-023 SHALL drive irq = match && irq_en, registered-free (combinational from flops).

Reset
REQ-024 SHALL, on resetn=0 (asynchronous, any state incl. mid-ACK), force FSM IDLE, iomem_ready=0, iomem_rdata=0, CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, PRESCALE=0, prescale counter 0, match=0, irq=0.
REQ-025 SHALL not complete an access interrupted by reset; the first post-reset access behaves per REQ-013.

Structure
REQ-026 SHALL place register offsets, CTRL bit indices and FSM state encodings in shared package picosoc_pkg.
REQ-027 SHALL implement the bus FSM/register file inline and the prescaler+counter as sub-module picosoc_timer_core.

Verification
REQ-028 SHALL cover: write COMPARE=5 (wstrb 4'hF), read back -> ready in cycle 2 of valid, rdata=32'h5.
REQ-029 SHALL cover: PRESCALE=3, CTRL=3'b011, COMPARE=2 -> COUNT increments every 4 cycles; match and irq rise on tick with COUNT==2; COUNT continues to 3.
REQ-030 SHALL cover: autoreload=1, PRESCALE=0, COMPARE=3 -> COUNT sequence 0,1,2,3,0,1 with match set at 3; STATUS write 1 clears match, irq falls next cycle.
REQ-031 SHALL cover: byte write wstrb=4'b0010 wdata=32'hAABBCCDD to COUNT=0 -> COUNT=32'h0000_CC00.
REQ-032 SHALL cover: access to BASE_ADDR+0x20 -> ready, rdata 0; access to 32'h0400_0000 -> ready never asserted over 10 cycles.
REQ-033 SHALL cover: resetn low mid-ACK and with match=1 -> ready, irq, COUNT drop to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/picosoc_pkg.sv
// Shared register map, control bit indices and bus FSM encoding
// for the picosoc iomem timer.
package picosoc_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_COUNT    = 8'h04;
    localparam logic [7:0] OFF_COMPARE  = 8'h08;
    localparam logic [7:0] OFF_PRESCALE = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    localparam int CTRL_W          = 3;
    localparam int CTRL_EN         = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_AUTORELOAD = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/picosoc_timer_core.sv
// Prescaler, 32-bit up-counter and compare-match flag.
// A bus write to the counter wins over a coincident tick.
module picosoc_timer_core
    import picosoc_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  autoreload,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [31:0]           compare,
    input  logic                  cnt_we,
    input  logic [31:0]           cnt_wdata,
    input  logic                  match_clr,
    output logic [31:0]           count,
    output logic                  match
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [31:0]           count_q;
    logic                  match_q;
    logic                  tick;
    logic                  hit;

    assign tick = en && (pre_q == prescale);
    assign hit  = (count_q == compare);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q   <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            pre_q <= (!en || tick) ? '0 : pre_q + PRESCALE_W'(1);

            if (cnt_we) begin
                count_q <= cnt_wdata;
            end else if (tick) begin
                count_q <= (hit && autoreload) ? 32'd0 : count_q + 32'd1;
            end

            // a new match outranks a same-cycle clear
            if (tick && hit) begin
                match_q <= 1'b1;
            end else if (match_clr) begin
                match_q <= 1'b0;
            end
        end
    end

    assign count = count_q;
    assign match = match_q;

endmodule

// File: rtl/picosoc_iomem_timer.sv
// iomem-bus timer peripheral: one-wait-state register window
// around a prescaled compare/match counter.
module picosoc_iomem_timer
    import picosoc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    bus_state_e state_q, state_d;

    logic                  sel, acc, wr;
    logic [7:0]            off;
    logic                  hit_ctrl, hit_count, hit_cmp;
    logic                  hit_pre, hit_status;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [31:0]           compare_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_mux;
    logic [31:0]           pre_ext;
    logic [31:0]           pre_merge;
    logic [31:0]           count;
    logic                  match;

    assign sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign acc = (state_q == ST_IDLE) && sel;
    assign wr  = acc && (iomem_wstrb != 4'b0000);
    assign off = iomem_addr[7:0];

    assign hit_ctrl   = (off == OFF_CTRL);
    assign hit_count  = (off == OFF_COUNT);
    assign hit_cmp    = (off == OFF_COMPARE);
    assign hit_pre    = (off == OFF_PRESCALE);
    assign hit_status = (off == OFF_STATUS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (sel) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_ext = '0;
        pre_ext[PRESCALE_W-1:0] = prescale_q;
    end

    assign pre_merge = merge_bytes(pre_ext, iomem_wdata, iomem_wstrb);

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            hit_ctrl:   rd_mux = {{(32-CTRL_W){1'b0}}, ctrl_q};
            hit_count:  rd_mux = count;
            hit_cmp:    rd_mux = compare_q;
            hit_pre:    rd_mux = pre_ext;
            hit_status: rd_mux = {31'd0, match};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            prescale_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (acc) rdata_q <= rd_mux;
            if (wr) begin
                if (hit_ctrl && iomem_wstrb[0]) begin
                    ctrl_q <= iomem_wdata[CTRL_W-1:0];
                end
                if (hit_cmp) begin
                    compare_q <= merge_bytes(compare_q, iomem_wdata, iomem_wstrb);
                end
                if (hit_pre) begin
                    prescale_q <= pre_merge[PRESCALE_W-1:0];
                end
            end
        end
    end

    picosoc_timer_core #(
        .PRESCALE_W (PRESCALE_W)
    ) u_core (
        .clk        (clk),
        .resetn     (resetn),
        .en         (ctrl_q[CTRL_EN]),
        .autoreload (ctrl_q[CTRL_AUTORELOAD]),
        .prescale   (prescale_q),
        .compare    (compare_q),
        .cnt_we     (wr && hit_count),
        .cnt_wdata  (merge_bytes(count, iomem_wdata, iomem_wstrb)),
        .match_clr  (wr && hit_status && iomem_wstrb[0] && iomem_wdata[0]),
        .count      (count),
        .match      (match)
    );

    assign iomem_ready = (state_q == ST_ACK);
    assign iomem_rdata = iomem_ready ? rdata_q : 32'd0;
    assign irq         = match && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Self-checking bench for picosoc_iomem_timer: register vector table,
// timing sequences and randomized runs against an arithmetic model.
module tb_picosoc_iomem_timer;

    localparam logic [31:0] B      = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = B + 32'h00;
    localparam logic [31:0] A_CNT  = B + 32'h04;
    localparam logic [31:0] A_CMP  = B + 32'h08;
    localparam logic [31:0] A_PRE  = B + 32'h0C;
    localparam logic [31:0] A_STAT = B + 32'h10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        irq;

    picosoc_iomem_timer dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // results of the most recent bus access
    logic [31:0] r_rd;
    logic [31:0] r_pre;
    int          r_lat;
    logic        r_got;
    int          r_edge;
    logic        r_irq;

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        r_got = 1'b0;
        r_lat = 0;
        r_rd  = 32'h0;
        r_pre = 32'h0;
        r_edge = 0;
        r_irq = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) r_pre = iomem_rdata;
            if (iomem_ready) begin
                r_got  = 1'b1;
                r_lat  = i;
                r_rd   = iomem_rdata;
                r_edge = cyc;
                r_irq  = irq;
                break;
            end
        end
        @(posedge clk);
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        access(a, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // polls irq at falling edges; returns edge index of rise or -1
    task automatic wait_irq(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq) begin
                t = cyc;
                break;
            end
        end
    endtask

    // reference: value of COUNT after n ticks from zero
    function automatic logic [31:0] ref_count(input int n, input int c,
                                              input bit ar);
        if (ar) return 32'(n % (c + 1));
        return 32'(n);
    endfunction

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic sel, input logic [31:0] exp);
        vec_t v;
        v.nm = nm; v.a = a; v.d = d; v.s = s; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        int e, r, s, w, t, p, c, idle;
        bit ar;
        logic [31:0] exp;

        vq.push_back(mk("rst_ctrl", A_CTRL, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("rst_count", A_CNT, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("rst_compare", A_CMP, 0, 4'h0, 1, 32'hFFFF_FFFF));
        vq.push_back(mk("rst_prescale", A_PRE, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("rst_status", A_STAT, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("wr_cmp", A_CMP, 32'h5, 4'hF, 1, 32'h0));
        vq.push_back(mk("rd_cmp", A_CMP, 0, 4'h0, 1, 32'h5));
        vq.push_back(mk("wr_pre", A_PRE, 32'hFFFF_FFFF, 4'hF, 1, 32'h0));
        vq.push_back(mk("rd_pre", A_PRE, 0, 4'h0, 1, 32'h0000_FFFF));
        vq.push_back(mk("wr_ctrl_nob0", A_CTRL, 32'hFF, 4'hE, 1, 32'h0));
        vq.push_back(mk("rd_ctrl0", A_CTRL, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("wr_ctrl", A_CTRL, 32'h6, 4'h1, 1, 32'h0));
        vq.push_back(mk("rd_ctrl", A_CTRL, 0, 4'h0, 1, 32'h6));
        vq.push_back(mk("wr_cnt_b1", A_CNT, 32'hAABB_CCDD, 4'h2, 1, 32'h0));
        vq.push_back(mk("rd_cnt_b1", A_CNT, 0, 4'h0, 1, 32'h0000_CC00));
        vq.push_back(mk("wr_cnt_b30", A_CNT, 32'h1234_5678, 4'h9, 1, 32'h0));
        vq.push_back(mk("rd_cnt_b30", A_CNT, 0, 4'h0, 1, 32'h1200_CC78));
        vq.push_back(mk("wr_unmap", B + 32'h20, 32'hFFFF_FFFF, 4'hF, 1, 32'h0));
        vq.push_back(mk("rd_unmap20", B + 32'h20, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("rd_unmap14", B + 32'h14, 0, 4'h0, 1, 32'h0));
        vq.push_back(mk("rd_other", 32'h0400_0000, 0, 4'h0, 0, 32'h0));
        vq.push_back(mk("wr_other", 32'h0400_0008, 32'h0, 4'hF, 0, 32'h0));
        vq.push_back(mk("rd_cmp_kept", A_CMP, 0, 4'h0, 1, 32'h5));
        vq.push_back(mk("wr_stat", A_STAT, 32'h1, 4'hF, 1, 32'h0));
        vq.push_back(mk("rd_stat", A_STAT, 0, 4'h0, 1, 32'h0));

        do_reset();
        @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_ready", {31'd0, iomem_ready}, 32'h0);

        foreach (vq[i]) begin
            access(vq[i].a, vq[i].d, vq[i].s);
            chk({vq[i].nm, "_ready"}, {31'd0, r_got}, {31'd0, vq[i].sel});
            if (vq[i].sel) begin
                chk({vq[i].nm, "_lat"}, 32'(r_lat), 32'd2);
                chk({vq[i].nm, "_idle_rdata"}, r_pre, 32'h0);
                if (vq[i].s == 4'h0) chk(vq[i].nm, r_rd, vq[i].exp);
            end
        end

        // prescale 3, compare 2: irq on the third tick, count moves on to 3
        do_reset();
        wr(A_PRE, 32'd3);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h3);
        e = r_edge;
        wait_irq(40, t);
        chk("pre3_irq_edge", 32'(t - e), 32'd12);
        rd(A_CNT);
        chk("pre3_count", r_rd, ref_count((r_edge - e - 1) / 4, 2, 0));
        chk("pre3_count3", r_rd, 32'd3);
        rd(A_STAT);
        chk("pre3_match", r_rd, 32'h1);

        // autoreload with compare 3, then w1c of STATUS
        do_reset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        e = r_edge;
        wait_irq(20, t);
        chk("ar_irq_edge", 32'(t - e), 32'd4);
        wr(A_CTRL, 32'h6);
        w = r_edge;
        rd(A_CNT);
        chk("ar_count", r_rd, ref_count(w - e, 3, 1));
        @(negedge clk);
        chk("ar_irq_held", {31'd0, irq}, 32'h1);
        access(A_STAT, 32'h1, 4'hE);
        chk("ar_clr_nostrb", {31'd0, r_irq}, 32'h1);
        access(A_STAT, 32'h1, 4'h1);
        chk("ar_clr_irq", {31'd0, r_irq}, 32'h0);
        rd(A_STAT);
        chk("ar_status", r_rd, 32'h0);

        // bus write to COUNT beats a coincident tick
        do_reset();
        wr(A_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        wr(A_CNT, 32'd100);
        w = r_edge;
        rd(A_CNT);
        chk("cnt_wr_prio", r_rd, 32'd100 + 32'(r_edge - w - 1));

        // clear of STATUS in the very cycle of a new match
        do_reset();
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h1);
        e = r_edge;
        access(A_STAT, 32'h1, 4'h1);
        w = r_edge;
        rd(A_STAT);
        s = r_edge;
        t = e + 3;
        exp = ((t >= w) && (t < s)) ? 32'h1 : 32'h0;
        chk("clr_vs_match", r_rd, exp);

        // reset asserted in the middle of an ACK with match set
        do_reset();
        wr(A_CMP, 32'd0);
        wr(A_CTRL, 32'h3);
        wait_irq(10, t);
        chk("r33_irq_pre", {31'd0, irq}, 32'h1);
        @(posedge clk);
        #1;
        iomem_valid = 1'b1;
        iomem_addr  = A_CNT;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("r33_ready_pre", {31'd0, iomem_ready}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("r33_ready", {31'd0, iomem_ready}, 32'h0);
        chk("r33_irq", {31'd0, irq}, 32'h0);
        chk("r33_rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        rd(A_CNT);
        chk("r33_post_lat", 32'(r_lat), 32'd2);
        chk("r33_count", r_rd, 32'h0);

        // randomized runs against the tick-count model
        for (int it = 0; it < 24; it++) begin
            p    = int'($urandom_range(0, 5));
            c    = int'($urandom_range(0, 10));
            ar   = 1'($urandom_range(0, 1));
            idle = int'($urandom_range(0, 30));
            do_reset();
            wr(A_PRE, 32'(p));
            wr(A_CMP, 32'(c));
            wr(A_CTRL, {29'd0, ar, 2'b11});
            e = r_edge;
            repeat (idle) @(posedge clk);
            rd(A_CNT);
            r = r_edge;
            chk("rnd_count", r_rd,
                ref_count((r - e - 1) / (p + 1), c, ar));
            rd(A_STAT);
            s = r_edge;
            exp = (((s - e - 1) / (p + 1)) >= c + 1) ? 32'h1 : 32'h0;
            chk("rnd_match", r_rd, exp);
            exp = (((s - e) / (p + 1)) >= c + 1) ? 32'h1 : 32'h0;
            chk("rnd_irq", {31'd0, r_irq}, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
